// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the dual-clock pixel FIFO: burst round-robin between two
// requesters, fill-level throttling, and sequencing of the FIFO's asynchronous clear.
module fifo_wr_arbiter #(
  parameter int DATA_W        = 20,
  parameter int USEDW_W       = 8,
  parameter int AF_THRESH     = 240,
  parameter int MAX_BURST     = 16,
  parameter int ACLR_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic               wrclk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic [DATA_W-1:0]  s0_data,
  input  logic               s0_valid,
  output logic               s0_ready,
  input  logic [DATA_W-1:0]  s1_data,
  input  logic               s1_valid,
  output logic               s1_ready,
  output logic [DATA_W-1:0]  fifo_data,
  output logic               fifo_wrreq,
  output logic               fifo_aclr,
  input  logic [USEDW_W-1:0] fifo_wrusedw,
  input  logic               fifo_wrfull,
  output logic               busy,
  output logic               ovf_err
);

  localparam int BURST_W = $clog2(MAX_BURST) + 1;
  localparam int SEQ_MAX = (ACLR_CYCLES > SETTLE_CYCLES) ? ACLR_CYCLES : SETTLE_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_SETTLE,
    ST_IDLE,
    ST_GRANT0,
    ST_GRANT1
  } state_t;

  state_t             state;
  logic [SEQ_W-1:0]   seq_cnt;
  logic [BURST_W-1:0] burst_cnt;
  logic               last_grant;

  logic thr;
  logic acc0;
  logic acc1;
  logic burst_last;

  // NOTE: every always_comb output gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    thr        = 1'b0;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    thr        = fifo_wrfull || (fifo_wrusedw >= USEDW_W'(AF_THRESH));
    s0_ready   = (state == ST_GRANT0) && !thr && !flush;
    s1_ready   = (state == ST_GRANT1) && !thr && !flush;
    acc0       = s0_valid && s0_ready;
    acc1       = s1_valid && s1_ready;
    burst_last = (burst_cnt == BURST_W'(MAX_BURST - 1));
  end

  // fifo_aclr and busy are registered alongside the state so the FIFO's async clear never glitches.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge wrclk) begin
    if (!reset_n) begin
      state      <= ST_FLUSH;
      seq_cnt    <= '0;
      burst_cnt  <= '0;
      last_grant <= 1'b1;
      fifo_aclr  <= 1'b1;
      busy       <= 1'b1;
      fifo_wrreq <= 1'b0;
      fifo_data  <= '0;
      ovf_err    <= 1'b0;
    end else begin
      fifo_wrreq <= acc0 || acc1;
      if (acc0)      fifo_data <= s0_data;
      else if (acc1) fifo_data <= s1_data;
      ovf_err <= ovf_err || (fifo_wrreq && fifo_wrfull);

      if (flush) begin
        // Held flush parks the clear counter at zero; the full count runs once flush drops.
        state     <= ST_FLUSH;
        seq_cnt   <= '0;
        burst_cnt <= '0;
        fifo_aclr <= 1'b1;
        busy      <= 1'b1;
        ovf_err   <= 1'b0;
      end else begin
        case (state)
          ST_FLUSH: begin
            if (seq_cnt == SEQ_W'(ACLR_CYCLES - 1)) begin
              state     <= ST_SETTLE;
              seq_cnt   <= '0;
              fifo_aclr <= 1'b0;
            end else begin
              seq_cnt <= seq_cnt + 1'b1;
            end
          end
          ST_SETTLE: begin
            if (seq_cnt == SEQ_W'(SETTLE_CYCLES - 1)) begin
              state   <= ST_IDLE;
              seq_cnt <= '0;
              busy    <= 1'b0;
            end else begin
              seq_cnt <= seq_cnt + 1'b1;
            end
          end
          ST_IDLE: begin
            // last_grant == 1 means s1 was served last, so s0 wins a tie.
            if (s0_valid && (!s1_valid || last_grant)) state <= ST_GRANT0;
            else if (s1_valid)                         state <= ST_GRANT1;
          end
          ST_GRANT0: begin
            if (!s0_valid || (acc0 && burst_last)) begin
              state      <= ST_IDLE;
              last_grant <= 1'b0;
              burst_cnt  <= '0;
            end else if (acc0) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
          ST_GRANT1: begin
            if (!s1_valid || (acc1 && burst_last)) begin
              state      <= ST_IDLE;
              last_grant <= 1'b1;
              burst_cnt  <= '0;
            end else if (acc1) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
          default: begin
            state     <= ST_FLUSH;
            seq_cnt   <= '0;
            burst_cnt <= '0;
            fifo_aclr <= 1'b1;
            busy      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: hand-written sequences for reset/burst/throttle/flush/overflow
// corners, then a table of per-cycle vectors with hand-computed expected outputs.
module tb_fifo_wr_arbiter;

  localparam int DW = 20;

  logic          wrclk;
  logic          reset_n;
  logic          flush;
  logic [DW-1:0] s0_data;
  logic          s0_valid;
  logic          s0_ready;
  logic [DW-1:0] s1_data;
  logic          s1_valid;
  logic          s1_ready;
  logic [DW-1:0] fifo_data;
  logic          fifo_wrreq;
  logic          fifo_aclr;
  logic [7:0]    fifo_wrusedw;
  logic          fifo_wrfull;
  logic          busy;
  logic          ovf_err;

  fifo_wr_arbiter dut (
    .wrclk        (wrclk),
    .reset_n      (reset_n),
    .flush        (flush),
    .s0_data      (s0_data),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s1_data      (s1_data),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .fifo_data    (fifo_data),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_aclr    (fifo_aclr),
    .fifo_wrusedw (fifo_wrusedw),
    .fifo_wrfull  (fifo_wrfull),
    .busy         (busy),
    .ovf_err      (ovf_err)
  );

  initial wrclk = 1'b0;
  always #5 wrclk = ~wrclk;

  int n_checks = 0;
  int n_errors = 0;

  // Source models: each requester presents a tagged, incrementing word stream.
  logic [15:0] s0_idx = 16'd0;
  logic [15:0] s1_idx = 16'd0;
  assign s0_data = {4'hA, s0_idx};
  assign s1_data = {4'hB, s1_idx};

  always @(posedge wrclk) begin
    if (s0_valid && s0_ready) s0_idx <= s0_idx + 16'd1;
    if (s1_valid && s1_ready) s1_idx <= s1_idx + 16'd1;
  end

  logic [DW-1:0] wr_q[$];
  logic [DW-1:0] exp_q[$];

  always @(negedge wrclk) begin
    if (fifo_wrreq) wr_q.push_back(fifo_data);
  end

  function automatic logic [DW-1:0] w0(input int i);
    return {4'hA, 16'(i)};
  endfunction

  function automatic logic [DW-1:0] w1(input int i);
    return {4'hB, 16'(i)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_q(input string name);
    int bad;
    bad = 0;
    check({name, "_count"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      if (wr_q[i] !== exp_q[i]) bad++;
    check({name, "_order"}, bad, 0);
  endtask

  task automatic nxt();
    @(negedge wrclk);
  endtask

  typedef struct {
    logic       rst_n;
    logic       fl;
    logic       v0;
    logic       v1;
    logic [7:0] usedw;
    logic       full;
    int         reps;
    logic       r0;
    logic       r1;
    logic       wrreq;
    logic       aclr;
    logic       bsy;
    logic       ovf;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  function automatic vec_t mk(input logic rst_n, input logic fl, input logic v0, input logic v1,
                              input logic [7:0] usedw, input logic full, input int reps,
                              input logic r0, input logic r1, input logic wrreq,
                              input logic aclr, input logic bsy, input logic ovf);
    vec_t v;
    v.rst_n = rst_n; v.fl = fl; v.v0 = v0; v.v1 = v1; v.usedw = usedw; v.full = full;
    v.reps = reps; v.r0 = r0; v.r1 = r1; v.wrreq = wrreq; v.aclr = aclr; v.bsy = bsy; v.ovf = ovf;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rdy;
    int aclr_n;
    int busy_n;
    int gap;
    int both;
    int n;

    // Per-cycle vectors applied after a fresh reset (inputs -> ready/wrreq/aclr/busy/ovf).
    //               rst fl v0 v1 usedw  full reps  r0 r1 wrq acl bsy ovf
    vecs[0]  = mk(1, 0, 0, 0, 8'd0,   0, 4,   0, 0, 0, 1, 1, 0); // FLUSH count
    vecs[1]  = mk(1, 0, 0, 0, 8'd0,   0, 8,   0, 0, 0, 0, 1, 0); // SETTLE count
    vecs[2]  = mk(1, 0, 0, 0, 8'd0,   0, 2,   0, 0, 0, 0, 0, 0); // IDLE, no requests
    vecs[3]  = mk(1, 0, 1, 1, 8'd0,   0, 1,   0, 0, 0, 0, 0, 0); // contention seen in IDLE
    vecs[4]  = mk(1, 0, 1, 1, 8'd240, 0, 1,   0, 0, 0, 0, 0, 0); // GRANT0 at threshold
    vecs[5]  = mk(1, 0, 1, 1, 8'd239, 0, 1,   1, 0, 0, 0, 0, 0); // just below threshold
    vecs[6]  = mk(1, 0, 1, 1, 8'd0,   1, 1,   0, 0, 1, 0, 0, 0); // wrfull during a write
    vecs[7]  = mk(1, 0, 1, 1, 8'd0,   0, 1,   1, 0, 0, 0, 0, 1); // overflow flagged
    vecs[8]  = mk(1, 0, 0, 1, 8'd0,   0, 1,   1, 0, 1, 0, 0, 1); // ready ignores valid
    vecs[9]  = mk(1, 0, 0, 1, 8'd0,   0, 1,   0, 0, 0, 0, 0, 1); // IDLE -> GRANT1
    vecs[10] = mk(1, 1, 0, 1, 8'd0,   0, 1,   0, 0, 0, 0, 0, 1); // flush gates ready
    vecs[11] = mk(1, 1, 1, 1, 8'd0,   0, 3,   0, 0, 0, 1, 1, 0); // flush held
    vecs[12] = mk(1, 0, 1, 1, 8'd0,   0, 4,   0, 0, 0, 1, 1, 0); // full clear count after drop
    vecs[13] = mk(1, 0, 1, 1, 8'd0,   0, 8,   0, 0, 0, 0, 1, 0); // SETTLE
    vecs[14] = mk(1, 0, 1, 1, 8'd0,   0, 1,   0, 0, 0, 0, 0, 0); // IDLE with contention
    vecs[15] = mk(1, 0, 1, 1, 8'd0,   0, 1,   0, 1, 0, 0, 0, 0); // s1 wins: last_grant kept
    vecs[16] = mk(1, 0, 0, 0, 8'd0,   0, 1,   0, 1, 1, 0, 0, 0); // s1 drops valid
    vecs[17] = mk(1, 0, 0, 0, 8'd0,   0, 1,   0, 0, 0, 0, 0, 0); // back in IDLE

    reset_n = 1'b0; flush = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    fifo_wrusedw = 8'd0; fifo_wrfull = 1'b0;

    // Reset values.
    repeat (3) nxt();
    #1;
    check("rst_aclr",    fifo_aclr,  1);
    check("rst_wrreq",   fifo_wrreq, 0);
    check("rst_data",    fifo_data,  0);
    check("rst_s0_rdy",  s0_ready,   0);
    check("rst_s1_rdy",  s1_ready,   0);
    check("rst_busy",    busy,       1);
    check("rst_ovf",     ovf_err,    0);

    // Release with s0 valid: aclr for 4 cycles, busy for 12, first ready on the 14th cycle.
    nxt();
    reset_n = 1'b1; s0_valid = 1'b1;
    first_rdy = -1; aclr_n = 0; busy_n = 0;
    for (int k = 0; k < 30 && first_rdy < 0; k++) begin
      #1;
      if (fifo_aclr) aclr_n++;
      if (busy) busy_n++;
      if (s0_ready) first_rdy = k + 1;
      else nxt();
    end
    check("post_rst_aclr_cycles", aclr_n, 4);
    check("post_rst_busy_cycles", busy_n, 12);
    check("post_rst_first_ready", first_rdy, 14);
    check("post_rst_s1_rdy", s1_ready, 0);

    // Both requesters continuously valid: 16-word bursts, s0 first, one gap per boundary.
    s1_valid = 1'b1;
    wr_q.delete();
    gap = 0; both = 0;
    for (int c = 0; c < 50; c++) begin
      if (!s0_ready && !s1_ready) gap++;
      if (s0_ready && s1_ready) both++;
      nxt(); #1;
    end
    s0_valid = 1'b0; s1_valid = 1'b0;
    check("rr_gap_cycles", gap, 2);
    check("rr_both_ready", both, 0);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(w0(i));
    for (int i = 0; i < 16; i++) exp_q.push_back(w1(i));
    for (int i = 16; i < 32; i++) exp_q.push_back(w0(i));
    check_q("rr_words");

    // s1 short burst of 5 words, then s0 granted one cycle after IDLE.
    nxt(); s1_valid = 1'b1; #1;
    check("grant_latency", s1_ready, 0);
    wr_q.delete();
    n = 0;
    for (int g = 0; g < 20 && n < 5; g++) begin
      nxt(); #1;
      if (s1_ready) n++;
    end
    check("s1_burst_len", n, 5);
    nxt(); s1_valid = 1'b0; #1;
    nxt(); s0_valid = 1'b1; #1;
    check("s1_end_idle_s0", s0_ready, 0);
    check("s1_end_idle_s1", s1_ready, 0);
    nxt(); #1;
    check("s0_grant_1cycle", s0_ready, 1);

    // Throttle mid-burst: same-cycle ready drop, no writes, resume with burst count intact.
    nxt(); #1;
    nxt(); #1;
    nxt(); fifo_wrusedw = 8'd240; #1;
    check("thr_ready_same_cycle", s0_ready, 0);
    nxt(); #1;
    check("thr_no_wrreq_1", fifo_wrreq, 0);
    nxt(); #1;
    check("thr_no_wrreq_2", fifo_wrreq, 0);
    check("thr_grant_held", s1_ready, 0);
    nxt(); fifo_wrusedw = 8'd239; #1;
    check("thr_resume", s0_ready, 1);
    n = 0;
    for (int g = 0; g < 40; g++) begin
      if (!s0_ready) break;
      n++;
      nxt(); #1;
    end
    check("thr_burst_remaining", n, 13);
    s0_valid = 1'b0;
    exp_q.delete();
    for (int i = 16; i < 21; i++) exp_q.push_back(w1(i));
    for (int i = 32; i < 48; i++) exp_q.push_back(w0(i));
    check_q("short_thr_words");

    // Overflow: wrfull coinciding with a write sets a sticky error.
    nxt(); s1_valid = 1'b1; #1;
    nxt(); #1;
    check("ovf_grant1", s1_ready, 1);
    nxt(); fifo_wrfull = 1'b1; #1;
    check("ovf_pre_wrreq", fifo_wrreq, 1);
    check("ovf_before", ovf_err, 0);
    check("full_throttle", s1_ready, 0);
    nxt(); fifo_wrfull = 1'b0; #1;
    check("ovf_set", ovf_err, 1);
    check("full_release", s1_ready, 1);
    nxt(); s1_valid = 1'b0; #1;
    repeat (3) nxt();
    #1;
    check("ovf_sticky", ovf_err, 1);

    // Flush on the 7th word of an s0 burst; last_grant (=1) survives, so s0 wins afterwards.
    nxt(); s0_valid = 1'b1; #1;
    n = 0;
    for (int g = 0; g < 20 && n < 6; g++) begin
      nxt(); #1;
      if (s0_ready) n++;
    end
    check("flush_pre_words", n, 6);
    nxt(); flush = 1'b1; #1;
    check("flush_gates_ready", s0_ready, 0);
    check("ovf_held_to_flush", ovf_err, 1);
    nxt(); flush = 1'b0; s1_valid = 1'b1; #1;
    check("flush_aclr", fifo_aclr, 1);
    check("ovf_cleared", ovf_err, 0);
    wr_q.delete();
    aclr_n = 1;
    for (int g = 0; g < 40; g++) begin
      nxt(); #1;
      if (fifo_aclr) aclr_n++;
      if (s0_ready || s1_ready) break;
    end
    check("flush_aclr_cycles", aclr_n, 4);
    check("post_flush_s0_first", s0_ready, 1);
    check("post_flush_s1_wait", s1_ready, 0);
    nxt(); s0_valid = 1'b0; s1_valid = 1'b0; #1;
    exp_q.delete();
    exp_q.push_back(w0(54));
    check_q("flush_no_drop");

    // Table-driven vectors from a fresh reset.
    nxt();
    reset_n = 1'b0; flush = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    fifo_wrusedw = 8'd0; fifo_wrfull = 1'b0;
    nxt(); #1;
    for (int i = 0; i < NVEC; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        nxt();
        reset_n      = vecs[i].rst_n;
        flush        = vecs[i].fl;
        s0_valid     = vecs[i].v0;
        s1_valid     = vecs[i].v1;
        fifo_wrusedw = vecs[i].usedw;
        fifo_wrfull  = vecs[i].full;
        #1;
        check($sformatf("vec%0d.%0d_s0_ready", i, r), s0_ready,   vecs[i].r0);
        check($sformatf("vec%0d.%0d_s1_ready", i, r), s1_ready,   vecs[i].r1);
        check($sformatf("vec%0d.%0d_wrreq", i, r),    fifo_wrreq, vecs[i].wrreq);
        check($sformatf("vec%0d.%0d_aclr", i, r),     fifo_aclr,  vecs[i].aclr);
        check($sformatf("vec%0d.%0d_busy", i, r),     busy,       vecs[i].bsy);
        check($sformatf("vec%0d.%0d_ovf", i, r),      ovf_err,    vecs[i].ovf);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
